// File: rtl/note_sequencer_pkg.sv
// Shared types and constants for the note sequencer: FSM state encoding,
// lane/score/combo widths and the saturating score update.
package ddr_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_PLAY   = 2'd1,
      ST_PAUSED = 2'd2,
      ST_OVER   = 2'd3
   } state_e;

   localparam int unsigned LANES      = 4;
   localparam int unsigned SCORE_W    = 16;
   localparam int unsigned COMBO_W    = 8;
   localparam int unsigned SCORE_BASE = 10;

   // Adds the per-hit award (base plus combo/8), clamping at all-ones.
   function automatic logic [SCORE_W-1:0] score_add(input logic [SCORE_W-1:0] s,
                                                    input logic [COMBO_W-1:0] c);
      logic [SCORE_W:0] sum;
      sum = {1'b0, s} + (SCORE_W+1)'(SCORE_BASE) + (SCORE_W+1)'(c[COMBO_W-1:3]);
      return sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
   endfunction

endpackage

// File: rtl/note_sequencer_lane_shift.sv
// One playfield lane: ROWS-bit shift register with spawn load, hit-window
// clear of the note nearest the hit row, and drop-out detection.
module lane_shift #(
   parameter int unsigned ROWS       = 16,
   parameter int unsigned HIT_WINDOW = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clear_i,
   input  logic            shift_i,
   input  logic            press_i,
   input  logic            spawn_i,
   output logic [ROWS-1:0] lane_o,
   output logic            hit_o,
   output logic            drop_o
);

   logic [ROWS-1:0] lane_q, lane_d, cleared;
   logic            found;

   // Press is resolved on the pre-shift contents; the shift then acts on the
   // cleared copy so a note hit on the tick edge never counts as dropped.
   always_comb begin
      cleared = lane_q;
      found   = 1'b0;
      if (press_i) begin
         for (int unsigned k = 0; k < HIT_WINDOW; k++) begin
            if (!found && lane_q[ROWS-1-k]) begin
               cleared[ROWS-1-k] = 1'b0;
               found             = 1'b1;
            end
         end
      end
   end

   assign hit_o  = found;
   assign drop_o = shift_i & cleared[ROWS-1];

   always_comb begin
      lane_d = cleared;
      if (clear_i) begin
         lane_d = '0;
      end else if (shift_i) begin
         lane_d = {cleared[ROWS-2:0], spawn_i};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lane_q <= '0;
      end else begin
         lane_q <= lane_d;
      end
   end

   assign lane_o = lane_q;

endmodule

// File: rtl/note_sequencer.sv
// Four-lane falling-note rhythm game core: playfield, scoring, combo and FSM.
// Optional macro NOTE_SEQ_CHORD_EN enables two-note chord spawns.
module note_sequencer
   import ddr_pkg::*;
#(
   parameter int unsigned ROWS       = 16,
   parameter int unsigned MISS_LIMIT = 8,
   parameter int unsigned DENSITY    = 6,
   parameter int unsigned HIT_WINDOW = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            random_num,
   input  logic                  step_tick,
   input  logic [3:0]            btn,
   input  logic                  start,
   input  logic                  pause,
   output logic [4*ROWS-1:0]     field,
   output logic                  hit,
   output logic                  miss,
   output logic [SCORE_W-1:0]    score,
   output logic [COMBO_W-1:0]    combo,
   output logic [1:0]            state
);

   localparam int unsigned MW = $clog2(MISS_LIMIT + 1);

   state_e              state_q, state_d;
   logic [SCORE_W-1:0]  score_q, score_d;
   logic [COMBO_W-1:0]  combo_q, combo_d;
   logic [MW-1:0]       miss_cnt_q, miss_cnt_d;
   logic                hit_q, hit_d, miss_q, miss_d;

   logic                active, lane_clear;
   logic [LANES-1:0]    spawn, press, lane_hit, lane_drop;
   logic [ROWS-1:0]     lane_v [LANES];

   assign active = (state_q == ST_PLAY) && !pause;
   assign press  = btn & {LANES{active}};

   always_comb begin
      spawn = '0;
      if ({29'b0, random_num[7:5]} < DENSITY) begin
         spawn[random_num[1:0]] = 1'b1;
`ifdef NOTE_SEQ_CHORD_EN
         if (random_num[4]) spawn[random_num[3:2]] = 1'b1;
`endif
      end
   end

`ifndef NOTE_SEQ_CHORD_EN
   logic unused_rn;
   assign unused_rn = ^random_num[4:2];
`endif

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      lane_shift #(
         .ROWS       (ROWS),
         .HIT_WINDOW (HIT_WINDOW)
      ) u_lane (
         .clk     (clk),
         .rst     (rst),
         .clear_i (lane_clear),
         .shift_i (step_tick & active),
         .press_i (press[g]),
         .spawn_i (spawn[g]),
         .lane_o  (lane_v[g]),
         .hit_o   (lane_hit[g]),
         .drop_o  (lane_drop[g])
      );
      assign field[g*ROWS +: ROWS] = lane_v[g];
   end

   always_comb begin
      state_d    = state_q;
      score_d    = score_q;
      combo_d    = combo_q;
      miss_cnt_d = miss_cnt_q;
      hit_d      = 1'b0;
      miss_d     = 1'b0;
      lane_clear = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d    = ST_PLAY;
               score_d    = '0;
               combo_d    = '0;
               miss_cnt_d = '0;
               lane_clear = 1'b1;
            end
         end
         ST_PLAY: begin
            if (pause) begin
               state_d = ST_PAUSED;
            end else begin
               // Lanes are folded in order so each hit lane adds its own award.
               for (int unsigned l = 0; l < LANES; l++) begin
                  if (press[l]) begin
                     if (lane_hit[l]) begin
                        hit_d = 1'b1;
                        if (combo_d != '1) combo_d = combo_d + 1'b1;
                        score_d = score_add(score_d, combo_d);
                     end else begin
                        combo_d = '0;
                     end
                  end
               end
               if (|lane_drop) begin
                  miss_d     = 1'b1;
                  combo_d    = '0;
                  miss_cnt_d = miss_cnt_q + MW'(1);
                  if (miss_cnt_d == MW'(MISS_LIMIT)) begin
                     state_d    = ST_OVER;
                     lane_clear = 1'b1;
                  end
               end
            end
         end
         ST_PAUSED: begin
            if (!pause) state_d = ST_PLAY;
         end
         ST_OVER: begin
            if (start) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         score_q    <= '0;
         combo_q    <= '0;
         miss_cnt_q <= '0;
         hit_q      <= 1'b0;
         miss_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         score_q    <= score_d;
         combo_q    <= combo_d;
         miss_cnt_q <= miss_cnt_d;
         hit_q      <= hit_d;
         miss_q     <= miss_d;
      end
   end

   assign hit   = hit_q;
   assign miss  = miss_q;
   assign score = score_q;
   assign combo = combo_q;
   assign state = state_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer: a behavioural model queues expected
// outputs per driven cycle; a monitor pops and compares after each edge.
module tb_note_sequencer;

   localparam int ROWS = 16;
   localparam int HW   = 2;
   localparam logic [1:0] S_IDLE = 2'd0, S_PLAY = 2'd1, S_PAUSED = 2'd2, S_OVER = 2'd3;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [7:0]       random_num = '0;
   logic             step_tick = 1'b0;
   logic [3:0]       btn = '0;
   logic             start = 1'b0;
   logic             pause = 1'b0;
   logic [4*ROWS-1:0] field;
   logic             hit, miss;
   logic [15:0]      score;
   logic [7:0]       combo;
   logic [1:0]       state;

   note_sequencer #(.ROWS(16), .MISS_LIMIT(8), .DENSITY(6), .HIT_WINDOW(2)) dut (
      .clk(clk), .rst(rst), .random_num(random_num), .step_tick(step_tick),
      .btn(btn), .start(start), .pause(pause), .field(field), .hit(hit),
      .miss(miss), .score(score), .combo(combo), .state(state)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]  st;
      logic [63:0] f;
      logic [15:0] sc;
      logic [7:0]  cb;
      logic        h;
      logic        m;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   miss_seen = 0;

   logic [1:0]  m_state;
   logic [63:0] m_field;
   int          m_score, m_combo, m_misses;

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         if ({state, field, score, combo, hit, miss} !== e) begin
            errors++;
            $display("FAIL scoreboard t=%0t: state %0d exp %0d, score %0d exp %0d, combo %0d exp %0d, hit %b exp %b, miss %b exp %b, field %h exp %h",
                     $time, state, e.st, score, e.sc, combo, e.cb, hit, e.h, miss, e.m, field, e.f);
         end
         if (miss === 1'b1) miss_seen++;
      end
   end

   task automatic model_reset();
      m_state = S_IDLE; m_field = '0; m_score = 0; m_combo = 0; m_misses = 0;
   endtask

   // One clock cycle of stimulus; the model predicts the post-edge outputs.
   task automatic drive(input logic st_v, input logic pa_v, input logic tk_v,
                        input logic [7:0] rn, input logic [3:0] b);
      exp_t e; logic [63:0] f; logic [3:0] sp; logic [15:0] ln;
      logic drop, found;
      int idx;
      @(negedge clk);
      start = st_v; pause = pa_v; step_tick = tk_v; random_num = rn; btn = b;
      f = m_field; e.h = 1'b0; e.m = 1'b0;
      case (m_state)
         S_IDLE: if (st_v) begin
            m_state = S_PLAY; f = '0; m_score = 0; m_combo = 0; m_misses = 0;
         end
         S_PLAY: if (pa_v) m_state = S_PAUSED;
         else begin
            for (int l = 0; l < 4; l++) begin
               if (b[l]) begin
                  found = 1'b0;
                  for (int k = 0; k < HW; k++) begin
                     idx = l*ROWS + ROWS-1-k;
                     if (!found && f[idx]) begin f[idx] = 1'b0; found = 1'b1; end
                  end
                  if (found) begin
                     e.h = 1'b1;
                     m_combo = (m_combo < 255) ? m_combo + 1 : 255;
                     m_score = m_score + 10 + m_combo / 8;
                     if (m_score > 65535) m_score = 65535;
                  end else m_combo = 0;
               end
            end
            if (tk_v) begin
               sp = '0;
               if (rn[7:5] < 3'd6) begin
                  sp[rn[1:0]] = 1'b1;
`ifdef NOTE_SEQ_CHORD_EN
                  if (rn[4]) sp[rn[3:2]] = 1'b1;
`endif
               end
               drop = 1'b0;
               for (int l = 0; l < 4; l++) begin
                  ln = f[l*ROWS +: ROWS];
                  drop = drop | ln[ROWS-1];
                  f[l*ROWS +: ROWS] = {ln[ROWS-2:0], sp[l]};
               end
               if (drop) begin
                  e.m = 1'b1; m_combo = 0; m_misses++;
                  if (m_misses == 8) begin m_state = S_OVER; f = '0; end
               end
            end
         end
         S_PAUSED: if (!pa_v) m_state = S_PLAY;
         default: if (st_v) m_state = S_IDLE;
      endcase
      m_field = f;
      e.st = m_state; e.f = f; e.sc = m_score[15:0]; e.cb = m_combo[7:0];
      sb.push_back(e);
      @(posedge clk);
      #2;
      start = 1'b0; btn = '0; step_tick = 1'b0;
   endtask

   task automatic restart();
      @(negedge clk);
      rst = 1'b1; pause = 1'b0;
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      drive(1, 0, 0, 8'h00, 4'b0000);
   endtask

   task automatic test_reset();
      model_reset();
      #12;
      checks++;
      if (state !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d exp 0", state); end
      checks++;
      if (field !== '0) begin errors++; $display("FAIL reset_field: got %h exp 0", field); end
      checks++;
      if ({score, combo} !== 24'd0) begin errors++; $display("FAIL reset_score_combo: got %0d/%0d exp 0/0", score, combo); end
      checks++;
      if ({hit, miss} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %b%b exp 00", hit, miss); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_single_hit();
      restart();
      for (int i = 0; i < 16; i++) drive(0, 0, 1, 8'h00, 4'b0000);
      checks++;
      if (field[15] !== 1'b1) begin errors++; $display("FAIL hit_row15: got %b exp 1", field[15]); end
      drive(0, 0, 0, 8'h00, 4'b0001);
      checks++;
      if ({hit, score, combo} !== {1'b1, 16'd10, 8'd1}) begin
         errors++; $display("FAIL single_hit: got hit=%b score=%0d combo=%0d exp 1/10/1", hit, score, combo);
      end
   endtask

   task automatic test_no_spawn();
      restart();
      miss_seen = 0;
      for (int i = 0; i < 20; i++) drive(0, 0, 1, 8'hE0, 4'b0000);
      checks++;
      if (field !== '0 || miss_seen != 0) begin
         errors++; $display("FAIL no_spawn: got field=%h misses=%0d exp 0/0", field, miss_seen);
      end
   endtask

   task automatic test_miss_out();
      int n;
      restart();
      miss_seen = 0;
      n = 0;
      while (state !== S_OVER && n < 40) begin
         drive(0, 0, 1, 8'h00, 4'b0000);
         n++;
      end
      checks++;
      if (miss_seen != 8 || state !== S_OVER || field !== '0) begin
         errors++; $display("FAIL miss_out: got misses=%0d state=%0d field=%h after %0d ticks exp 8/3/0", miss_seen, state, field, n);
      end
      drive(1, 0, 0, 8'h00, 4'b0000);
      checks++;
      if (state !== S_IDLE) begin errors++; $display("FAIL over_to_idle: got %0d exp 0", state); end
   endtask

   task automatic test_tick_and_hit();
      restart();
      drive(0, 0, 1, 8'h00, 4'b0000);
      for (int i = 0; i < 15; i++) drive(0, 0, 1, 8'hE0, 4'b0000);
      drive(0, 0, 1, 8'hE0, 4'b0001);
      checks++;
      if ({hit, miss, score} !== {1'b1, 1'b0, 16'd10}) begin
         errors++; $display("FAIL tick_and_hit: got hit=%b miss=%b score=%0d exp 1/0/10", hit, miss, score);
      end
   endtask

   task automatic test_pause();
      logic [63:0] f0, fx;
      logic [15:0] s0;
      restart();
      drive(0, 0, 1, 8'h00, 4'b0000);
      drive(0, 0, 1, 8'h01, 4'b0000);
      f0 = field; s0 = score;
      drive(0, 1, 0, 8'h00, 4'b0000);
      for (int i = 0; i < 20; i++) drive(0, 1, 1, 8'h02, 4'b0011);
      checks++;
      if (field !== f0 || score !== s0 || state !== S_PAUSED) begin
         errors++; $display("FAIL pause_hold: got field=%h score=%0d state=%0d exp %h/%0d/2", field, score, state, f0, s0);
      end
      drive(0, 0, 0, 8'h00, 4'b0000);
      drive(0, 0, 1, 8'hE0, 4'b0000);
      for (int l = 0; l < 4; l++) fx[l*ROWS +: ROWS] = f0[l*ROWS +: ROWS] << 1;
      checks++;
      if (field !== fx || state !== S_PLAY) begin
         errors++; $display("FAIL pause_resume: got field=%h state=%0d exp %h/1", field, state, fx);
      end
   endtask

   task automatic test_multi_lane();
      restart();
      drive(0, 0, 1, 8'h00, 4'b0000);
      drive(0, 0, 1, 8'h01, 4'b0000);
      for (int i = 0; i < 14; i++) drive(0, 0, 1, 8'hE0, 4'b0000);
      drive(0, 0, 0, 8'h00, 4'b0011);
      checks++;
      if ({hit, score, combo} !== {1'b1, 16'd20, 8'd2}) begin
         errors++; $display("FAIL multi_lane: got hit=%b score=%0d combo=%0d exp 1/20/2", hit, score, combo);
      end
      drive(0, 0, 0, 8'h00, 4'b0100);
      checks++;
      if ({hit, miss, combo, score} !== {1'b0, 1'b0, 8'd0, 16'd20}) begin
         errors++; $display("FAIL empty_press: got hit=%b miss=%b combo=%0d score=%0d exp 0/0/0/20", hit, miss, combo, score);
      end
   endtask

   task automatic test_chord();
      logic [63:0] fx;
      restart();
      drive(0, 0, 1, 8'h1C, 4'b0000);
`ifdef NOTE_SEQ_CHORD_EN
      fx = 64'h0001_0000_0000_0001;
`else
      fx = 64'h0000_0000_0000_0001;
`endif
      checks++;
      if (field !== fx) begin errors++; $display("FAIL chord: got %h exp %h", field, fx); end
   endtask

   task automatic test_midgame_reset();
      restart();
      for (int i = 0; i < 17; i++) drive(0, 0, 1, 8'h00, 4'b0000);
      @(negedge clk);
      step_tick = 1'b1; btn = 4'b0001;
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({state, field, score, combo, hit, miss} !== '0) begin
         errors++; $display("FAIL midgame_reset: got state=%0d field=%h score=%0d combo=%0d hit=%b miss=%b exp all 0",
                            state, field, score, combo, hit, miss);
      end
      model_reset();
      @(negedge clk);
      rst = 1'b0; step_tick = 1'b0; btn = '0;
      drive(0, 0, 0, 8'h00, 4'b0000);
      checks++;
      if ({state, hit, miss} !== {S_IDLE, 2'b00}) begin
         errors++; $display("FAIL after_reset: got state=%0d hit=%b miss=%b exp 0/0/0", state, hit, miss);
      end
   endtask

   initial begin
      test_reset();
      test_single_hit();
      test_no_spawn();
      test_miss_out();
      test_tick_and_hit();
      test_pause();
      test_multi_lane();
      test_chord();
      test_midgame_reset();
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left exp 0", sb.size()); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 Parameter ROWS, default 16: playfield rows per lane; row 0 is the spawn row, row ROWS-1 is the hit row.
REQ-002 Parameter MISS_LIMIT, default 8: misses that end the game.
REQ-003 Parameter DENSITY, default 6: a note spawns when random_num[7:5] < DENSITY.
REQ-004 Parameter HIT_WINDOW, default 2: a press scores on the bottom HIT_WINDOW rows.
REQ-005 clk  in  1  system clock; every register is clocked on its rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 random_num  in  8  pseudo-random value from the upstream generator; it is sampled only on step_tick.
REQ-008 step_tick  in  1  one-cycle pulse that advances the playfield by one row.
REQ-009 btn  in  4  debounced one-cycle press pulses; one bit per lane.
REQ-010 start  in  1  one-cycle pulse that starts the game or returns to idle.
REQ-011 pause  in  1  level signal from a switch; high freezes play.
REQ-012 field  out  4*ROWS  lane-major playfield bitmap (bit lane*ROWS+row) for the display.
REQ-013 hit, miss  out  1 each  one-cycle event pulses.
REQ-014 score  out  16  accumulated score.
REQ-015 combo  out  8  current consecutive-hit count.
REQ-016 state  out  2  current FSM state, for display.

Function
REQ-017 FSM states: IDLE, PLAY, PAUSED, OVER.
- IDLE->PLAY on start; this clears field, score, combo and the miss count.
- PLAY->PAUSED while pause=1; PAUSED->PLAY when pause=0.
- PLAY->OVER when the miss count reaches MISS_LIMIT.
- OVER->IDLE on start.
REQ-018 In PLAY, on step_tick, every lane shifts one row toward ROWS-1, and row 0 loads the spawn pattern.
REQ-019 Spawn: when random_num[7:5] < DENSITY, set lane random_num[1:0] in row 0; otherwise row 0 is empty.
REQ-020 A set bit that shifts out of row ROWS-1 causes a miss:
- pulse miss for one cycle;
- increment the miss count (at most one per tick, even if several lanes drop);
- clear combo.
REQ-021 In PLAY, btn[i] with lane i set in any of the bottom HIT_WINDOW rows:
- clear the lowest such bit;
- pulse hit;
- combo += 1, saturating at 255;
- score += 10 + combo[7:3], saturating at 0xFFFF.
REQ-022 btn[i] with no note in the window clears combo; no miss is counted.
REQ-023 Multiple btn bits in one cycle are each evaluated independently; the hit pulse is asserted once and score adds once per hit lane.
REQ-024 When step_tick and btn occur in the same cycle, hit evaluation uses the pre-shift field, and the shift is then applied to the cleared result.
REQ-025 In IDLE, PAUSED and OVER, step_tick and btn are ignored; field, score and combo hold.
REQ-026 Entering OVER clears field on the same edge; score holds until the next IDLE->PLAY.
REQ-027 All outputs are registered; hit and miss appear exactly one cycle after the causing input edge.

Reset
REQ-028 While rst=1, these hold regardless of clk:
- state=IDLE;
- field=0;
- score=0, combo=0, miss count=0;
- hit=0, miss=0.
REQ-029 rst asserted mid-game aborts the game with no residual pulses; the first cycle after release is in IDLE.

Configuration
REQ-030 Macro NOTE_SEQ_CHORD_EN:
- When defined, a spawn with random_num[4]=1 also sets lane random_num[3:2] in row 0, producing a two-note chord (a single note if both lanes are equal).
- When undefined, random_num[4:2] is ignored and at most one note spawns per tick.

Structure
REQ-031 Shared package ddr_pkg holds:
- the state enum (2 bits);
- lane count 4;
- score width 16 and combo width 8;
- the score base constant 10.
REQ-032 One sub-module, lane_shift, is instantiated 4 times. Each instance holds one lane's ROWS-bit shift register and performs:
- spawn load;
- hit-window clear;
- drop-out detection.

Verification
REQ-033 Reset then start, with random_num=8'h00 on each tick -> lane 0 note reaches row 15 after 16 ticks; btn=4'b0001 -> hit=1, score=10, combo=1.
REQ-034 random_num=8'hE0 (random_num[7:5]=7 >= DENSITY) on all ticks -> field stays 0 and no miss occurs.
REQ-035 Let 8 notes fall unpressed -> miss pulses 8 times; state=OVER, field=0; start -> IDLE.
REQ-036 Note in row 15 with step_tick and btn in the same cycle -> hit=1, miss=0.
REQ-037 pause=1 for 20 ticks -> field and score unchanged; pause=0 -> shifting resumes on the next tick.
REQ-038 With NOTE_SEQ_CHORD_EN defined, random_num=8'h1C -> lanes 0 and 3 are both set in row 0; with it undefined, only lane 0 is set.
